dp_ctrl_seq: RTL
================

# dp_ctrl_seq

Transfer sequencer that sits directly downstream of the AXI-Lite register file and consumes its register outputs. Software writes a word count and a start bit over AXI-Lite. The block then gates an AXI-Stream path for exactly that many beats and marks the final beat with tlast. It writes busy/done/error status and counters back into the register file through the file's user write port, which has priority over AXI writes.

## Interface
- DATA_WIDTH, 32, register width; equals the register file DATA_WIDTH.
- REG_NUM, 32, register count; equals the register file REG_NUM; must be ≥5.
- AXIS_WIDTH, 64, stream data width.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reg_rdata  in  DATA_WIDTH*REG_NUM  flattened register values, register i at [i*DATA_WIDTH +: DATA_WIDTH].
- reg_write  out  REG_NUM  per-register write strobe into the register file.
- reg_wdata  out  DATA_WIDTH*REG_NUM  write data, same packing as reg_rdata.
- s_axis_tdata / tvalid / tready  in/in/out  AXIS_WIDTH/1/1  input stream.
- m_axis_tdata / tvalid / tready / tlast  out/out/in/out  AXIS_WIDTH/1/1/1  output stream.
- busy  out  1  high in RUN.

## Operation
- Register map, word index:
  - 0 CTRL: bit0 START, bit1 ABORT; software read/write; the block clears these bits.
  - 1 LEN: beat count, 32-bit unsigned.
  - 2 STATUS: bit0 busy, bit1 done, bit2 zero_len error, bit3 aborted.
  - 3 BEAT_CNT: beats transferred.
  - 4 CYC_CNT: RUN cycles elapsed.
  - Registers 2–4 are owned by the block. reg_write[4:2] is high every cycle after reset release, so AXI writes to them are lost. reg_write[REG_NUM-1:5] is always 0.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN: when CTRL.START=1 and LEN≠0.
  - Latch LEN into len_q.
  - Zero beat_cnt and cyc_cnt.
  - Set STATUS = busy only.
  - Pulse reg_write[0] for one cycle with wdata = CTRL & ~3.
- IDLE → DONE: when CTRL.START=1 and LEN=0.
  - STATUS = done | zero_len.
  - Same CTRL clear pulse.
  - No beats move.
- RUN:
  - m_axis_tvalid = s_axis_tvalid; s_axis_tready = m_axis_tready; tdata passes through combinationally.
  - A beat occurs when s_axis_tvalid & m_axis_tready; each beat does beat_cnt+1.
  - m_axis_tlast = (beat_cnt == len_q-1).
  - cyc_cnt increments every RUN cycle and saturates at 2^32-1.
- RUN → DONE:
  - On the tlast beat, STATUS = done.
  - On CTRL.ABORT=1, STATUS = done | aborted and CTRL is cleared with the same pulse. Abort wins over a same-cycle final beat; that beat is still counted.
- DONE → IDLE unconditionally after one cycle. This masks the one-cycle lag before the CTRL clear takes effect, so START is not re-sampled as still set.
- Outside RUN: m_axis_tvalid=0, s_axis_tready=0, m_axis_tlast=0.
- ABORT seen in IDLE: cleared via the CTRL pulse; no status change.
- STATUS done/aborted/zero_len stay set until the next accepted START.
- The CTRL clear pulse overrides a same-cycle AXI write to CTRL. This is accepted behaviour; software must not rewrite CTRL while START is pending.

## Timing
- Reset (rst_n=0, asynchronous), all outputs:
  - state IDLE; busy=0.
  - reg_write=0; reg_wdata=0.
  - m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=0, m_axis_tdata=0.
  - Counters and len_q = 0.
- First cycle after release: reg_write[4:2]=1 with STATUS=0.
- Reset asserted mid-RUN: transfer abandoned and the tlast beat is never issued. Software sees STATUS from the register file's own reset.
- START sampled at edge E: busy=1 and RUN from E. The reg_write[0] pulse is high E to E+1, and the register file shows CTRL.START=0 after E+1.
- Stream path has zero latency (combinational passthrough); no buffering. tvalid must not depend on tready.
- Status registers show the value from the previous cycle (one-cycle lag behind internal counters).
- LEN changes during RUN are ignored; len_q is used.

## Test plan
- LEN=4, START, source and sink always ready → exactly 4 beats, tlast on beat 4 only. After the run: STATUS=0x2, BEAT_CNT=4, CYC_CNT=4, CTRL=0.
- LEN=3, sink tready toggling 1010… → 3 beats, source data preserved in order, no beat while tready=0, tlast on beat 3.
- LEN=0, START → no tvalid, STATUS=0x6, CTRL.START cleared. The FSM passes DONE→IDLE with no second trigger.
- LEN=100, ABORT after 10 beats → STATUS=0x A(done|aborted), BEAT_CNT=10, tvalid low from the next cycle.
- Back-to-back: START with LEN=1, then START again with LEN=2 after return to IDLE → 1 then 2 beats. STATUS cleared to busy at the second start.
- rst_n pulsed low for one cycle mid-RUN (beat 5 of 8) → outputs 0 immediately (asynchronous), FSM IDLE, no tlast.

Source files
------------

// File: rtl/dp_ctrl_seq_if.sv
// Register-file and AXI-Stream bundle between the register file, the stream
// endpoints and the transfer sequencer.
interface dp_ctrl_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32,
    parameter int AXIS_WIDTH = 64
);
    logic [DATA_WIDTH*REG_NUM-1:0] reg_rdata;
    logic [REG_NUM-1:0]            reg_write;
    logic [DATA_WIDTH*REG_NUM-1:0] reg_wdata;
    logic [AXIS_WIDTH-1:0]         s_axis_tdata;
    logic                          s_axis_tvalid;
    logic                          s_axis_tready;
    logic [AXIS_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          m_axis_tlast;

    modport master (
        input  reg_rdata, s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output reg_write, reg_wdata, s_axis_tready,
               m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output reg_rdata, s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  reg_write, reg_wdata, s_axis_tready,
               m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/dp_ctrl_seq.sv
// Transfer sequencer: gates an AXI-Stream path for LEN beats on CTRL.START and
// reports busy/done/error status and counters back into the register file.
module dp_ctrl_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32,
    parameter int AXIS_WIDTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    dp_ctrl_seq_if.master bus,
    output logic          busy
);
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_len, r_beat, r_cyc, r_ctrl_wdata;
    logic          r_done, r_zlen, r_abort, r_live, r_ctrl_wr;

    logic [DW-1:0] w_ctrl, w_len;
    logic          w_run, w_beat, w_last;
    logic          w_ctrl_clr, w_go, w_zero, w_abt, w_fin;
    logic          w_unused_rdata;

    assign w_ctrl         = bus.reg_rdata[0 +: DW];
    assign w_len          = bus.reg_rdata[DW +: DW];
    assign w_unused_rdata = ^bus.reg_rdata[DW*REG_NUM-1:2*DW];

    assign w_run  = (r_state == RUN);
    assign w_beat = w_run & bus.s_axis_tvalid & bus.m_axis_tready;
    assign w_last = w_run && (r_beat == r_len - DW'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_ctrl_clr  = 1'b0;
        w_go        = 1'b0;
        w_zero      = 1'b0;
        w_abt       = 1'b0;
        w_fin       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_ctrl[0]) begin
                    w_ctrl_clr = 1'b1;
                    if (w_len != '0) begin
                        w_go        = 1'b1;
                        w_state_nxt = RUN;
                    end else begin
                        w_zero      = 1'b1;
                        w_state_nxt = DONE;
                    end
                end else if (w_ctrl[1]) begin
                    w_ctrl_clr = 1'b1;
                end
            end
            RUN: begin
                // Abort takes priority over a coincident final beat.
                if (w_ctrl[1]) begin
                    w_ctrl_clr  = 1'b1;
                    w_abt       = 1'b1;
                    w_state_nxt = DONE;
                end else if (w_beat && w_last) begin
                    w_fin       = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            // One dead cycle so the not-yet-cleared CTRL.START is not re-sampled.
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_len        <= '0;
            r_beat       <= '0;
            r_cyc        <= '0;
            r_ctrl_wdata <= '0;
            r_done       <= 1'b0;
            r_zlen       <= 1'b0;
            r_abort      <= 1'b0;
            r_live       <= 1'b0;
            r_ctrl_wr    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_live       <= 1'b1;
            r_ctrl_wr    <= w_ctrl_clr;
            r_ctrl_wdata <= w_ctrl & {{(DW-2){1'b1}}, 2'b00};
            if (w_go) begin
                r_len   <= w_len;
                r_beat  <= '0;
                r_cyc   <= '0;
                r_done  <= 1'b0;
                r_zlen  <= 1'b0;
                r_abort <= 1'b0;
            end
            if (w_zero) begin
                r_done  <= 1'b1;
                r_zlen  <= 1'b1;
                r_abort <= 1'b0;
            end
            if (w_run) begin
                r_beat <= r_beat + DW'(w_beat);
                if (~&r_cyc) r_cyc <= r_cyc + DW'(1);
            end
            if (w_abt) begin
                r_done  <= 1'b1;
                r_abort <= 1'b1;
            end
            if (w_fin) r_done <= 1'b1;
        end
    end

    assign busy              = w_run;
    assign bus.m_axis_tvalid = w_run & bus.s_axis_tvalid;
    assign bus.s_axis_tready = w_run & bus.m_axis_tready;
    assign bus.m_axis_tdata  = w_run ? bus.s_axis_tdata : {AXIS_WIDTH{1'b0}};
    assign bus.m_axis_tlast  = w_last;

    // Status words are driven from registered state, so the file lags by a cycle.
    always_comb begin
        bus.reg_write            = '0;
        bus.reg_write[0]         = r_ctrl_wr;
        bus.reg_write[4:2]       = {3{r_live}};
        bus.reg_wdata            = '0;
        bus.reg_wdata[0 +: DW]   = r_ctrl_wdata;
        bus.reg_wdata[2*DW +: DW] = {{(DW-4){1'b0}}, r_abort, r_zlen, r_done, w_run};
        bus.reg_wdata[3*DW +: DW] = r_beat;
        bus.reg_wdata[4*DW +: DW] = r_cyc;
    end
endmodule
